frame_update_arbiter: RTL and testbench
=======================================

# frame_update_arbiter

Round-robin scheduler that owns the shared object-position registers read by the drawing stages (shot, rectangle and later sprites) of the VGA pipeline. Game-logic requesters post new coordinates at any time. The arbiter commits them only during vertical blanking, one requester per pixel clock, so the drawing chain never sees a position change mid-frame. It also emits a per-frame tick and a frame counter that drive game timing.

## Interface
- N_REQ, 4 — number of requesters and object slots; slot i belongs to requester i
- XW, 11 — x coordinate width (matches hcount)
- YW, 11 — y coordinate width (matches vcount)
- XMAX, 799 — largest legal x (800x600 mode at 40 MHz)
- YMAX, 599 — largest legal y

Ports:
- pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- vblnk_in  in  1  vertical blanking flag from the timing generator
- req  in  N_REQ  per-requester update request; held high until its ack
- x_in  in  N_REQ*XW  requested x; slot i occupies bits [i*XW +: XW]
- y_in  in  N_REQ*YW  requested y; same packing as x_in
- ack  out  N_REQ  one-cycle pulse; slot committed on this edge
- xpos_out  out  N_REQ*XW  committed x per slot
- ypos_out  out  N_REQ*YW  committed y per slot
- frame_tick  out  1  one-cycle pulse at each vblank start
- frame_cnt  out  16  frames since reset; wraps 0xFFFF→0
- busy  out  1  high while in state ARB

## Operation
- Reset: state ACTIVE, vblnk_d=0, rr_ptr=0, ack=0, frame_tick=0, frame_cnt=0, busy=0, all xpos/ypos=0.
- vblnk_d is vblnk_in registered. The rising edge is vblnk_in & ~vblnk_d.
- ACTIVE: no grants. On a rising edge: next state ARB, frame_tick=1 for one cycle, frame_cnt+1.
- ARB: each cycle with vblnk_in=1, take eligible = req & ~ack.
  - Select the first eligible index searching upward from rr_ptr, wrapping at N_REQ.
  - On the next edge: ack[sel]=1; xpos/ypos slot sel loads x_in/y_in sampled in the selection cycle; rr_ptr = sel+1 mod N_REQ.
  - If eligible=0: no ack, rr_ptr unchanged.
- ARB with vblnk_in=0: next state ACTIVE, no selection. A grant registered on the final vblank cycle still completes.
- Requests pending at vblank end wait for the next vblank. req is never dropped internally.
- The ~ack mask prevents a double grant while a requester deasserts req in response to ack.
- Requester contract: drop req, or post new data with req held, in the cycle after it sees ack. A requester that keeps req high is granted again after at most N_REQ-1 other grants.
- At most one ack bit is set per cycle.
- rst mid-vblank: returns to ACTIVE. No grants occur for the rest of that vblank, because no rising edge is seen until the next frame.

## Timing
- Rising edge seen at cycle t → frame_tick, busy and state ARB valid at t+1. The first selection happens at t+1; its ack and position update are visible at t+2.
- Throughput: one commit per cycle during vblank, giving N_REQ commits within N_REQ cycles when all requesters are pending.
- xpos_out/ypos_out change only on edges where the matching ack goes high, and therefore only while vblnk_in=1 or on the edge immediately after it falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- FRAME_ARB_CLAMP_EN defined: the committed x is min(x_in, XMAX) and the committed y is min(y_in, YMAX), so off-screen requests land on the screen edge.
- FRAME_ARB_CLAMP_EN undefined: x_in and y_in are committed unmodified.

## Structure
- The shared package frame_arb_pkg holds:
  - the state enum (ACTIVE, ARB)
  - default XW, YW, XMAX and YMAX
  - the frame-counter width constant
- Sub-module rr_picker: combinational round-robin priority selector.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: valid, one-hot grant, binary index.
  - Reusable by later arbiters.

## Test plan
- Reset with vblnk_in=1, then release → no ack or frame_tick until the next 0→1 edge of vblnk_in; all positions read 0.
- req=4'b0001 with x=100, y=200 asserted during active video → no ack. At vblank start ack[0] occurs at t+2 and slot 0 becomes (100,200); frame_cnt=1.
- All four req high with rr_ptr=0 → ack order 0,1,2,3 on consecutive cycles. At the next vblank with req[0] and req[3] high and rr_ptr=0 → order 0,3.
- req[2] raised on the last vblank cycle → the grant completes on the falling-edge cycle. req[1] raised one cycle later → no ack until the next vblank.
- x_in=1023, y_in=700 with FRAME_ARB_CLAMP_EN defined → commits (799,599). Without the macro → commits (1023,700).
- Force frame_cnt to 0xFFFF, then one vblank → wraps to 0x0000 with frame_tick=1.

Source files
------------

// File: rtl/frame_arb_pkg.sv
// frame_arb_pkg
//   Shared types and defaults for the frame update arbiter.
//   - state_e      : arbiter states (ACTIVE = drawing, ARB = committing in vblank)
//   - DEF_XW/YW    : default coordinate widths, matching hcount/vcount
//   - DEF_XMAX/YMAX: largest on-screen coordinate for 800x600
//   - FRAME_CNT_W  : width of the free-running frame counter
package frame_arb_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    ARB    = 1'b1
  } state_e;

  localparam int DEF_XW      = 11;
  localparam int DEF_YW      = 11;
  localparam int DEF_XMAX    = 799;
  localparam int DEF_YMAX    = 599;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_update_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin priority selector. Picks the first set bit of
//   eligible_i searching upward from ptr_i, wrapping at N.
//   Ports:
//     eligible_i [N]  : candidate vector
//     ptr_i      [IW] : index with highest priority this cycle
//     valid_o         : any candidate present
//     grant_o    [N]  : one-hot winner (zero when !valid_o)
//     idx_o      [IW] : binary winner index (zero when !valid_o)
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int          s;
    logic [IW-1:0] j;
    valid_o = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    s       = 0;
    j       = '0;
    // Walk from farthest to nearest so the nearest eligible index wins.
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      j = IW'(s);
      if (eligible_i[j]) begin
        valid_o    = 1'b1;
        idx_o      = j;
        grant_o    = '0;
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_update_arbiter.sv
// frame_update_arbiter
//   Owns the object-position registers read by the drawing stages. Requesters
//   post coordinates at any time; commits happen only during vertical
//   blanking, one requester per pclk, round-robin. Also produces a per-frame
//   tick and a 16-bit frame counter.
//   Build option: FRAME_ARB_CLAMP_EN clamps committed x/y to XMAX/YMAX.
//   Ports:
//     pclk, rst        : pixel clock, synchronous active-high reset
//     vblnk_in         : vertical blanking from the timing generator
//     req [N_REQ]      : update request, held until ack
//     x_in / y_in      : requested coordinates, slot i at [i*W +: W]
//     ack [N_REQ]      : one-cycle commit pulse
//     xpos_out/ypos_out: committed coordinates per slot
//     frame_tick       : one-cycle pulse at vblank start
//     frame_cnt        : frames since reset, wrapping
//     busy             : arbiter is in ARB
//
//   state  | meaning
//   ACTIVE | active video, positions frozen, waiting for vblank rising edge
//   ARB    | vertical blanking, one commit per cycle from pending requests
module frame_update_arbiter
  import frame_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int XW    = DEF_XW,
  parameter int YW    = DEF_YW,
  parameter int XMAX  = DEF_XMAX,
  parameter int YMAX  = DEF_YMAX
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   vblnk_in,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*XW-1:0]    x_in,
  input  logic [N_REQ*YW-1:0]    y_in,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ*XW-1:0]    xpos_out,
  output logic [N_REQ*YW-1:0]    ypos_out,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef FRAME_ARB_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic                   vblnk_q;
  logic                   armed_q;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   frame_tick_q, frame_tick_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [N_REQ*XW-1:0]    xpos_q, xpos_d;
  logic [N_REQ*YW-1:0]    ypos_q, ypos_d;

  logic                   vblnk_rise;
  logic [N_REQ-1:0]       eligible;
  logic                   pick_valid;
  logic [N_REQ-1:0]       pick_grant;
  logic [IW-1:0]          pick_idx;
  logic [XW-1:0]          x_sel, x_commit;
  logic [YW-1:0]          y_sel, y_commit;

  // vblnk_q is cleared by reset, so a reset inside vblank would otherwise look
  // like a fresh rising edge. armed_q only allows edges after a low sample.
  assign vblnk_rise = vblnk_in & ~vblnk_q & armed_q;

  // Masking the previous ack stops a regrant while the winner drops req.
  assign eligible = req & ~ack_q;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .valid_o    (pick_valid),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx)
  );

  assign x_sel    = x_in[int'(pick_idx)*XW +: XW];
  assign y_sel    = y_in[int'(pick_idx)*YW +: YW];
  assign x_commit = (CLAMP && (x_sel > XW'(XMAX))) ? XW'(XMAX) : x_sel;
  assign y_commit = (CLAMP && (y_sel > YW'(YMAX))) ? YW'(YMAX) : y_sel;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    ack_d        = '0;
    frame_tick_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    unique case (state_q)
      ACTIVE: begin
        if (vblnk_rise) begin
          state_d      = ARB;
          frame_tick_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
        end
      end
      ARB: begin
        if (!vblnk_in) begin
          state_d = ACTIVE;
        end else if (pick_valid) begin
          ack_d                            = pick_grant;
          xpos_d[int'(pick_idx)*XW +: XW]  = x_commit;
          ypos_d[int'(pick_idx)*YW +: YW]  = y_commit;
          rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ACTIVE;
      vblnk_q      <= 1'b0;
      armed_q      <= 1'b0;
      rr_ptr_q     <= '0;
      ack_q        <= '0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      xpos_q       <= '0;
      ypos_q       <= '0;
    end else begin
      state_q      <= state_d;
      vblnk_q      <= vblnk_in;
      armed_q      <= armed_q | ~vblnk_in;
      rr_ptr_q     <= rr_ptr_d;
      ack_q        <= ack_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
    end
  end

  assign ack        = ack_q;
  assign xpos_out   = xpos_q;
  assign ypos_out   = ypos_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q == ARB);

endmodule

// File: tb/tb_frame_update_arbiter.sv
module tb_frame_update_arbiter;

  localparam int N  = 4;
  localparam int XW = 11;
  localparam int YW = 11;

  logic            pclk = 1'b0;
  logic            rst;
  logic            vblnk_in;
  logic [N-1:0]    req;
  logic [N*XW-1:0] x_in;
  logic [N*YW-1:0] y_in;
  logic [N-1:0]    ack;
  logic [N*XW-1:0] xpos_out;
  logic [N*YW-1:0] ypos_out;
  logic            frame_tick;
  logic [15:0]     frame_cnt;
  logic            busy;

  int checks = 0;
  int errors = 0;

  frame_update_arbiter dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .req        (req),
    .x_in       (x_in),
    .y_in       (y_in),
    .ack        (ack),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y);
    x_in[i*XW +: XW] = XW'(x);
    y_in[i*YW +: YW] = YW'(y);
  endtask

  function automatic logic [63:0] xs(input int i);
    return 64'(xpos_out[i*XW +: XW]);
  endfunction

  function automatic logic [63:0] ys(input int i);
    return 64'(ypos_out[i*YW +: YW]);
  endfunction

  initial begin
    rst = 1'b1; vblnk_in = 1'b1; req = '0; x_in = '0; y_in = '0;
    for (int i = 0; i < N; i++) set_slot(i, 1 + i, 2 + i);
    repeat (3) tick();

    // Release reset inside vblank with everyone requesting: must stay idle.
    rst = 1'b0; req = 4'b1111;
    tick();
    chk("rst_ack", 64'(ack), 0);
    chk("rst_tick", 64'(frame_tick), 0);
    chk("rst_cnt", 64'(frame_cnt), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_xpos", 64'(xpos_out), 0);
    chk("rst_ypos", 64'(ypos_out), 0);
    repeat (3) tick();
    chk("rst_vbl_ack", 64'(ack), 0);
    chk("rst_vbl_busy", 64'(busy), 0);
    chk("rst_vbl_xpos", 64'(xpos_out), 0);

    // Request during active video: no ack.
    vblnk_in = 1'b0; req = 4'b0001;
    set_slot(0, 100, 200); set_slot(3, 30, 40);
    repeat (3) tick();
    chk("act_ack", 64'(ack), 0);
    chk("act_busy", 64'(busy), 0);

    // Frame 1: tick at t+1, ack[0] at t+2.
    vblnk_in = 1'b1;
    tick();
    chk("f1_tick", 64'(frame_tick), 1);
    chk("f1_busy", 64'(busy), 1);
    chk("f1_cnt", 64'(frame_cnt), 1);
    chk("f1_ack_early", 64'(ack), 0);
    tick();
    chk("f1_ack0", 64'(ack), 64'h1);
    chk("f1_x0", xs(0), 100);
    chk("f1_y0", ys(0), 200);
    chk("f1_tick_off", 64'(frame_tick), 0);
    req = 4'b1000;
    tick();
    chk("f1_ack3", 64'(ack), 64'h8);
    chk("f1_x3", xs(3), 30);
    chk("f1_y3", ys(3), 40);
    req = '0;
    tick();
    chk("f1_idle", 64'(ack), 0);
    vblnk_in = 1'b0;
    tick();
    chk("f1_end_busy", 64'(busy), 0);

    // Frame 2: all four pending, pointer at 0 -> 0,1,2,3.
    for (int i = 0; i < N; i++) set_slot(i, 10 + i, 20 + i);
    req = 4'b1111;
    vblnk_in = 1'b1;
    tick();
    chk("f2_cnt", 64'(frame_cnt), 2);
    for (int i = 0; i < N; i++) begin
      tick();
      chk($sformatf("f2_ack_%0d", i), 64'(ack), 64'(1) << i);
      req[i] = 1'b0;
    end
    tick();
    chk("f2_idle", 64'(ack), 0);
    chk("f2_x0", xs(0), 10);
    chk("f2_y3", ys(3), 23);
    chk("f2_x2", xs(2), 12);
    vblnk_in = 1'b0;
    tick();

    // Frame 3: req[0] and req[3] -> 0 then 3.
    set_slot(0, 50, 60); set_slot(3, 70, 80);
    req = 4'b1001;
    vblnk_in = 1'b1;
    tick();
    tick();
    chk("f3_ack0", 64'(ack), 64'h1);
    req = 4'b1000;
    tick();
    chk("f3_ack3", 64'(ack), 64'h8);
    chk("f3_x3", xs(3), 70);
    req = '0;
    tick();
    chk("f3_idle", 64'(ack), 0);
    vblnk_in = 1'b0;
    tick();

    // Frame 4: req[2] on the last vblank cycle completes after the fall.
    vblnk_in = 1'b1;
    tick();
    chk("f4_cnt", 64'(frame_cnt), 4);
    tick();
    set_slot(2, 300, 400); req = 4'b0100;
    tick();
    vblnk_in = 1'b0;
    chk("f4_ack2", 64'(ack), 64'h4);
    chk("f4_x2", xs(2), 300);
    chk("f4_y2", ys(2), 400);
    set_slot(1, 111, 222); req = 4'b0010;
    tick();
    chk("f4_late_ack", 64'(ack), 0);
    chk("f4_late_busy", 64'(busy), 0);
    repeat (2) tick();
    chk("f4_wait_ack", 64'(ack), 0);
    chk("f4_x1_held", xs(1), 11);

    // Frame 5: the pending req[1] is served.
    vblnk_in = 1'b1;
    tick();
    chk("f5_tick", 64'(frame_tick), 1);
    tick();
    chk("f5_ack1", 64'(ack), 64'h2);
    chk("f5_x1", xs(1), 111);
    chk("f5_y1", ys(1), 222);
    req = '0; vblnk_in = 1'b0;
    tick();

    // Frame 6: off-screen request.
    set_slot(0, 1023, 700); req = 4'b0001;
    vblnk_in = 1'b1;
    tick();
    tick();
    chk("f6_ack0", 64'(ack), 64'h1);
`ifdef FRAME_ARB_CLAMP_EN
    chk("f6_x0_clamp", xs(0), 799);
    chk("f6_y0_clamp", ys(0), 599);
`else
    chk("f6_x0_raw", xs(0), 1023);
    chk("f6_y0_raw", ys(0), 700);
`endif
    req = '0; vblnk_in = 1'b0;
    tick();

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("wrap_pre", 64'(frame_cnt), 64'hFFFF);
    vblnk_in = 1'b1;
    tick();
    chk("wrap_cnt", 64'(frame_cnt), 0);
    chk("wrap_tick", 64'(frame_tick), 1);
    vblnk_in = 1'b0;
    tick();

    // Reset mid-vblank: no grant until the next frame.
    req = 4'b0010; set_slot(1, 5, 6);
    vblnk_in = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("rstmid_ack", 64'(ack), 0);
    chk("rstmid_busy", 64'(busy), 0);
    chk("rstmid_x1", xs(1), 0);
    chk("rstmid_cnt", 64'(frame_cnt), 0);
    vblnk_in = 1'b0;
    tick();
    vblnk_in = 1'b1;
    tick();
    chk("rstmid_cnt1", 64'(frame_cnt), 1);
    tick();
    chk("rstmid_ack1", 64'(ack), 64'h2);
    chk("rstmid_x1b", xs(1), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
